// File: rtl/merlin_pfu_mo_pkg.sv
// Shared RISC-V fetch definitions for the multi-outstanding pre-fetch unit:
// XLEN, start-of-fetch-id codes and the packed layouts of both queue entries.
package merlin_pfu_mo_pkg;

  localparam int RV_XLEN_X   = 5;
  localparam int RV_XLEN     = 2 ** RV_XLEN_X;
  localparam int RV_SOFID_SZ = 2;

  localparam logic [RV_SOFID_SZ-1:0] RV_SOFID_RUN  = 2'd0;
  localparam logic [RV_SOFID_SZ-1:0] RV_SOFID_JUMP = 2'd1;

  // Address queue entry: one per request on the ibus, popped by its response.
  typedef struct packed {
    logic [RV_SOFID_SZ-1:0] sofid;
    logic [RV_XLEN-1:0]     pc;
  } aq_entry_t;

  // Instruction FIFO entry as presented to the decoder.
  typedef struct packed {
    logic [RV_SOFID_SZ-1:0] sofid;
    logic                   ferr;
    logic [RV_XLEN-1:0]     pc;
    logic [RV_XLEN-1:0]     ins;
  } if_entry_t;

  // Clears the byte-offset bits so the bus only sees word addresses.
  function automatic logic [RV_XLEN-1:0] word_align(input logic [RV_XLEN-1:0] a);
    logic [RV_XLEN-1:0] mask;
    mask = RV_XLEN'((2 ** (RV_XLEN_X - 3)) - 1);
    return a & ~mask;
  endfunction

endpackage

// File: rtl/merlin_fifo.sv
// Synchronous FIFO with flush, clock enable and optional write-to-read passthrough.
// The head entry is read combinationally so the consumer sees it without a cycle of latency.
module merlin_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_X     = 2,
  parameter int PASSTHROUGH = 0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_X;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_X:0] wptr_reg, rptr_reg;
  logic             stored_empty, full, bypass, push, pop;

  assign stored_empty = (wptr_reg == rptr_reg);
  assign full = (wptr_reg[DEPTH_X] != rptr_reg[DEPTH_X]) &&
                (wptr_reg[DEPTH_X-1:0] == rptr_reg[DEPTH_X-1:0]);

  // In passthrough mode a write into an empty FIFO is presented directly;
  // if it is also read in that cycle it never needs to be stored.
  assign bypass = (PASSTHROUGH != 0) && stored_empty && wr;
  assign empty  = stored_empty & ~bypass;
  assign dout   = ((PASSTHROUGH != 0) && stored_empty) ? din : mem[rptr_reg[DEPTH_X-1:0]];
  assign push   = wr & ~full & ~(bypass & rd);
  assign pop    = rd & ~stored_empty;

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else if (en) begin
      if (flush) begin
        wptr_reg <= '0;
        rptr_reg <= '0;
      end else begin
        if (push) wptr_reg <= wptr_reg + 1'b1;
        if (pop)  rptr_reg <= rptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !flush && push) mem[wptr_reg[DEPTH_X-1:0]] <= din;
  end

endmodule

// File: rtl/merlin_pfu_mo.sv
// Multi-outstanding instruction pre-fetch unit: streams ibus requests under FIFO credit,
// drops stale responses by count after a vector. Optional MERLIN_PFU_PERF_EN adds perf counters.
module merlin_pfu_mo
  import merlin_pfu_mo_pkg::*;
#(
  parameter int                 C_FIFO_PASSTHROUGH  = 0,
  parameter int                 C_FIFO_DEPTH_X      = 2,
  parameter int                 C_MAX_OUTSTANDING_X = 1,
  parameter logic [RV_XLEN-1:0] C_RESET_VECTOR      = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clk_en_i,
  input  logic                   ireqready_i,
  output logic                   ireqvalid_o,
  output logic [1:0]             ireqhpl_o,
  output logic [RV_XLEN-1:0]     ireqaddr_o,
  output logic                   irspready_o,
  input  logic                   irspvalid_i,
  input  logic                   irsprerr_i,
  input  logic [RV_XLEN-1:0]     irspdata_i,
  output logic                   ids_dav_o,
  input  logic                   ids_ack_i,
  output logic [RV_SOFID_SZ-1:0] ids_sofid_o,
  output logic [31:0]            ids_ins_o,
  output logic                   ids_ferr_o,
  output logic [RV_XLEN-1:0]     ids_pc_o,
  input  logic                   exs_pc_wr_i,
  input  logic [RV_XLEN-1:0]     exs_pc_din_i,
  input  logic [1:0]             exs_hpl_i
`ifdef MERLIN_PFU_PERF_EN
  ,
  output logic [31:0]            perf_req_o,
  output logic [31:0]            perf_drop_o
`endif
);

  localparam int                 OUT_W    = C_MAX_OUTSTANDING_X + 1;
  localparam int                 CRD_W    = C_FIFO_DEPTH_X + 1;
  localparam logic [OUT_W-1:0]   OUT_MAX  = OUT_W'(2 ** C_MAX_OUTSTANDING_X);
  localparam logic [CRD_W-1:0]   CRD_FULL = CRD_W'(2 ** C_FIFO_DEPTH_X);
  localparam logic [RV_XLEN-1:0] PC_STEP  = RV_XLEN'(2 ** (RV_XLEN_X - 3));

  logic [RV_XLEN-1:0] pc_reg, pc_next;
  logic [OUT_W-1:0]   outstanding_reg, outstanding_next;
  logic [OUT_W-1:0]   discard_reg, discard_next;
  logic [CRD_W-1:0]   credit_reg, credit_next;
  logic               vectoring_reg, vectoring_next;

  logic      req, rsp, vec, drop, keep, ack;
  logic      aq_empty, if_empty;
  aq_entry_t aq_din, aq_dout;
  if_entry_t if_din, if_dout;

  assign vec  = exs_pc_wr_i;
  assign rsp  = irspvalid_i;
  assign req  = ireqvalid_o & ireqready_i;
  // A response arriving in the vector cycle is already stale, so it is dropped too.
  assign drop = rsp & ((discard_reg != '0) | vec);
  assign keep = rsp & ~drop;
  assign ack  = ids_ack_i & ids_dav_o & ~vec;

  assign ireqvalid_o = ~vec & (credit_reg != '0) & (outstanding_reg < OUT_MAX);
  assign ireqhpl_o   = exs_hpl_i;
  assign ireqaddr_o  = word_align(pc_reg);
  assign irspready_o = 1'b1;

  always_comb begin
    pc_next          = pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    credit_next      = credit_reg;
    vectoring_next   = vectoring_reg;
    if (vec) begin
      pc_next          = exs_pc_din_i;
      vectoring_next   = 1'b1;
      credit_next      = CRD_FULL;
      discard_next     = discard_reg + outstanding_reg - OUT_W'(rsp);
      outstanding_next = outstanding_reg - OUT_W'(rsp);
    end else begin
      if (req) begin
        pc_next        = pc_reg + PC_STEP;
        vectoring_next = 1'b0;
      end
      credit_next      = credit_reg - CRD_W'(req) + CRD_W'(ack);
      outstanding_next = outstanding_reg + OUT_W'(req) - OUT_W'(rsp);
      if (drop) discard_next = discard_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_reg          <= C_RESET_VECTOR;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      credit_reg      <= CRD_FULL;
      vectoring_reg   <= 1'b1;
    end else if (clk_en_i) begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      credit_reg      <= credit_next;
      vectoring_reg   <= vectoring_next;
    end
  end

  assign aq_din = '{sofid: (vectoring_reg ? RV_SOFID_JUMP : RV_SOFID_RUN), pc: pc_reg};

  merlin_fifo #(
    .WIDTH      ($bits(aq_entry_t)),
    .DEPTH_X    (C_MAX_OUTSTANDING_X),
    .PASSTHROUGH(0)
  ) u_addr_q (
    .clk  (clk_i),
    .srst (reset_i),
    .en   (clk_en_i),
    .flush(vec),
    .wr   (req),
    .din  (aq_din),
    .rd   (keep),
    .dout (aq_dout),
    .empty(aq_empty)
  );

  assign if_din = '{sofid: aq_dout.sofid, ferr: irsprerr_i, pc: aq_dout.pc, ins: irspdata_i};

  merlin_fifo #(
    .WIDTH      ($bits(if_entry_t)),
    .DEPTH_X    (C_FIFO_DEPTH_X),
    .PASSTHROUGH(C_FIFO_PASSTHROUGH)
  ) u_ins_fifo (
    .clk  (clk_i),
    .srst (reset_i),
    .en   (clk_en_i),
    .flush(vec),
    .wr   (keep),
    .din  (if_din),
    .rd   (ack),
    .dout (if_dout),
    .empty(if_empty)
  );

  assign ids_dav_o   = ~if_empty;
  assign ids_sofid_o = if_dout.sofid;
  assign ids_ferr_o  = if_dout.ferr;
  assign ids_pc_o    = if_dout.pc;
  assign ids_ins_o   = if_dout.ins;

  // Every response must match an address queue entry.
  always_ff @(posedge clk_i) begin
    if (!reset_i && clk_en_i) begin
      assert (!(irspvalid_i && (outstanding_reg == '0) && aq_empty));
    end
  end

`ifdef MERLIN_PFU_PERF_EN
  logic [31:0] perf_req_reg, perf_drop_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_req_reg  <= '0;
      perf_drop_reg <= '0;
    end else if (clk_en_i) begin
      if (req)  perf_req_reg  <= perf_req_reg + 1'b1;
      if (drop) perf_drop_reg <= perf_drop_reg + 1'b1;
    end
  end

  assign perf_req_o  = perf_req_reg;
  assign perf_drop_o = perf_drop_reg;
`endif

endmodule

// File: tb/tb_merlin_pfu_mo.sv
// Directed self-checking bench for merlin_pfu_mo: a queued ibus model with programmable
// latency/error, a decoder ack switch, and one task per scenario with inline checks.
module tb_merlin_pfu_mo;
  import merlin_pfu_mo_pkg::*;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        clk_en_i = 1'b1;
  logic        ireqready_i = 1'b0;
  logic        ireqvalid_o;
  logic [1:0]  ireqhpl_o;
  logic [31:0] ireqaddr_o;
  logic        irspready_o;
  logic        irspvalid_i = 1'b0;
  logic        irsprerr_i = 1'b0;
  logic [31:0] irspdata_i = '0;
  logic        ids_dav_o;
  logic        ids_ack_i = 1'b0;
  logic [1:0]  ids_sofid_o;
  logic [31:0] ids_ins_o;
  logic        ids_ferr_o;
  logic [31:0] ids_pc_o;
  logic        exs_pc_wr_i = 1'b0;
  logic [31:0] exs_pc_din_i = '0;
  logic [1:0]  exs_hpl_i = 2'b11;
`ifdef MERLIN_PFU_PERF_EN
  logic [31:0] perf_req_o, perf_drop_o;
`endif

  merlin_pfu_mo dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ireqready_i(ireqready_i), .ireqvalid_o(ireqvalid_o), .ireqhpl_o(ireqhpl_o),
    .ireqaddr_o(ireqaddr_o), .irspready_o(irspready_o), .irspvalid_i(irspvalid_i),
    .irsprerr_i(irsprerr_i), .irspdata_i(irspdata_i), .ids_dav_o(ids_dav_o),
    .ids_ack_i(ids_ack_i), .ids_sofid_o(ids_sofid_o), .ids_ins_o(ids_ins_o),
    .ids_ferr_o(ids_ferr_o), .ids_pc_o(ids_pc_o), .exs_pc_wr_i(exs_pc_wr_i),
    .exs_pc_din_i(exs_pc_din_i), .exs_hpl_i(exs_hpl_i)
`ifdef MERLIN_PFU_PERF_EN
    , .perf_req_o(perf_req_o), .perf_drop_o(perf_drop_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int due; } bus_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; logic [1:0] sofid; logic ferr; } ent_t;

  bus_t        bq[$];
  logic [31:0] req_log[$];
  ent_t        got[$];
  int n_pass = 0, n_total = 0;
  int cyc = 0, lat = 1, err_at = -1, rsp_idx = 0;
  int inflight = 0, max_inflight = 0;

  // ibus slave: answers in request order, lat cycles after acceptance
  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (irspvalid_i) begin
        void'(bq.pop_front());
        rsp_idx++;
      end
      cyc++;
      irspvalid_i = 1'b0;
      irsprerr_i  = 1'b0;
      irspdata_i  = '0;
      if (bq.size() > 0 && bq[0].due <= cyc) begin
        irspvalid_i = 1'b1;
        irspdata_i  = bq[0].addr ^ K;
        irsprerr_i  = (rsp_idx == err_at);
      end
    end
  end

  // request / consumed-entry monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (!reset_i && ireqvalid_o && ireqready_i) begin
        bq.push_back('{addr: ireqaddr_o, due: cyc + lat});
        req_log.push_back(ireqaddr_o);
        inflight++;
      end
      if (irspvalid_i) inflight--;
      if (inflight > max_inflight) max_inflight = inflight;
      if (!reset_i && ids_dav_o && ids_ack_i && !exs_pc_wr_i)
        got.push_back('{pc: ids_pc_o, ins: ids_ins_o, sofid: ids_sofid_o, ferr: ids_ferr_o});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    ireqready_i = 1'b0;
    ids_ack_i   = 1'b0;
    exs_pc_wr_i = 1'b0;
    for (int i = 0; i < 50 && bq.size() != 0; i++) @(posedge clk_i);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    req_log.delete();
    got.delete();
    rsp_idx = 0; err_at = -1; inflight = 0; max_inflight = 0;
  endtask

  // stop requesting and let the bus and FIFO empty; bounded
  task automatic drain(input string name);
    @(posedge clk_i); #1;
    ireqready_i = 1'b0;
    ids_ack_i   = 1'b1;
    repeat (lat + 12) @(posedge clk_i);
    #1;
    n_total++;
    if (bq.size() != 0 || ids_dav_o !== 1'b0)
      $display("FAIL %s_drain: pending=%0d dav=%b required pending=0 dav=0", name, bq.size(), ids_dav_o);
    else n_pass++;
  endtask

  task automatic test_reset;
    apply_reset();
    @(negedge clk_i);
    n_total++;
    if (ids_dav_o !== 1'b0) $display("FAIL reset_dav: got %b want 0", ids_dav_o); else n_pass++;
    n_total++;
    if (ireqvalid_o !== 1'b1) $display("FAIL reset_reqvalid: got %b want 1", ireqvalid_o); else n_pass++;
    n_total++;
    if (ireqaddr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", ireqaddr_o); else n_pass++;
    n_total++;
    if (irspready_o !== 1'b1 || ireqhpl_o !== 2'b11)
      $display("FAIL reset_ties: rspready=%b hpl=%b want 1/11", irspready_o, ireqhpl_o);
    else n_pass++;
  endtask

  task automatic test_stream;
    int bad;
    apply_reset();
    lat = 1;
    ids_ack_i = 1'b1;
    ireqready_i = 1'b1;
    repeat (12) @(posedge clk_i);
    #1 ireqready_i = 1'b0;
    drain("stream");
    n_total++;
    if (req_log.size() != 12) $display("FAIL stream_reqs: got %0d want 12", req_log.size()); else n_pass++;
    n_total++;
    if (got.size() != 12) $display("FAIL stream_entries: got %0d want 12", got.size()); else n_pass++;
    n_total++;
    if (got.size() == 0 || got[0].sofid !== RV_SOFID_JUMP)
      $display("FAIL stream_first_jump: got %0d entries sofid0=%0d want %0d", got.size(),
               (got.size() > 0) ? got[0].sofid : 2'bxx, RV_SOFID_JUMP);
    else n_pass++;
    bad = 0;
    foreach (got[i]) begin
      if (got[i].pc !== 32'(4 * i) || got[i].ins !== (32'(4 * i) ^ K) || got[i].ferr !== 1'b0) bad++;
      if (i > 0 && got[i].sofid !== RV_SOFID_RUN) bad++;
    end
    foreach (req_log[i]) if (req_log[i] !== 32'(4 * i)) bad++;
    n_total++;
    if (bad != 0) $display("FAIL stream_order: %0d bad fields want 0", bad); else n_pass++;
`ifdef MERLIN_PFU_PERF_EN
    n_total++;
    if (perf_req_o !== 32'd12 || perf_drop_o !== 32'd0)
      $display("FAIL stream_perf: req=%0d drop=%0d want 12/0", perf_req_o, perf_drop_o);
    else n_pass++;
`endif
  endtask

  task automatic test_outstanding;
    apply_reset();
    lat = 3;
    ids_ack_i = 1'b1;
    ireqready_i = 1'b1;
    @(negedge clk_i);
    n_total++;
    if (ireqvalid_o !== 1'b1) $display("FAIL outst_first: valid=%b want 1", ireqvalid_o); else n_pass++;
    @(negedge clk_i);
    @(negedge clk_i);
    n_total++;
    if (ireqvalid_o !== 1'b0 || req_log.size() != 2)
      $display("FAIL outst_limit: valid=%b reqs=%0d want 0/2", ireqvalid_o, req_log.size());
    else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (ireqvalid_o !== 1'b0 || irspvalid_i !== 1'b1)
      $display("FAIL outst_hold: valid=%b rsp=%b want 0/1", ireqvalid_o, irspvalid_i);
    else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (ireqvalid_o !== 1'b1) $display("FAIL outst_resume: valid=%b want 1", ireqvalid_o); else n_pass++;
    repeat (20) @(negedge clk_i);
    drain("outst");
    n_total++;
    if (max_inflight != 2) $display("FAIL outst_max: got %0d want 2", max_inflight); else n_pass++;
    n_total++;
    if (got.size() != req_log.size())
      $display("FAIL outst_count: entries=%0d reqs=%0d want equal", got.size(), req_log.size());
    else n_pass++;
  endtask

  task automatic test_credit;
    apply_reset();
    lat = 1;
    ids_ack_i = 1'b0;
    ireqready_i = 1'b1;
    repeat (10) @(negedge clk_i);
    n_total++;
    if (req_log.size() != 4 || ireqvalid_o !== 1'b0 || ids_dav_o !== 1'b1)
      $display("FAIL credit_stall: reqs=%0d valid=%b dav=%b want 4/0/1", req_log.size(), ireqvalid_o, ids_dav_o);
    else n_pass++;
    @(posedge clk_i); #1 ids_ack_i = 1'b1;
    @(posedge clk_i); #1 ids_ack_i = 1'b0;
    repeat (6) @(negedge clk_i);
    n_total++;
    if (req_log.size() != 5) $display("FAIL credit_one_more: reqs=%0d want 5", req_log.size()); else n_pass++;
    n_total++;
    if (got.size() != 1 || got[0].pc !== 32'h0)
      $display("FAIL credit_ack_entry: entries=%0d want 1 with pc 0", got.size());
    else n_pass++;
    drain("credit");
    n_total++;
    if (got.size() != 5) $display("FAIL credit_total: entries=%0d want 5", got.size()); else n_pass++;
  endtask

  task automatic test_vector;
    apply_reset();
    lat = 3;
    ids_ack_i = 1'b1;
    ireqready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    exs_pc_wr_i  = 1'b1;
    exs_pc_din_i = 32'h100;
    @(negedge clk_i);
    n_total++;
    if (ireqvalid_o !== 1'b0 || req_log.size() != 2)
      $display("FAIL vec_cycle: valid=%b reqs=%0d want 0/2", ireqvalid_o, req_log.size());
    else n_pass++;
    @(posedge clk_i); #1 exs_pc_wr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_total++;
    if (ids_dav_o !== 1'b0) $display("FAIL vec_dropped: dav=%b want 0", ids_dav_o); else n_pass++;
    repeat (10) @(negedge clk_i);
    drain("vec");
    n_total++;
    if (got.size() < 2 || got[0].pc !== 32'h100 || got[0].sofid !== RV_SOFID_JUMP ||
        got[1].pc !== 32'h104 || got[1].sofid !== RV_SOFID_RUN)
      $display("FAIL vec_target: entries=%0d pc0=%h want 100 JUMP then 104 RUN", got.size(),
               (got.size() > 0) ? got[0].pc : 32'hx);
    else n_pass++;
    n_total++;
    if (got.size() + 2 != req_log.size())
      $display("FAIL vec_drop_count: entries=%0d reqs=%0d want reqs-2", got.size(), req_log.size());
    else n_pass++;
`ifdef MERLIN_PFU_PERF_EN
    n_total++;
    if (perf_drop_o !== 32'd2) $display("FAIL vec_perf_drop: got %0d want 2", perf_drop_o); else n_pass++;
`endif
  endtask

  task automatic test_vector_collision;
    apply_reset();
    lat = 2;
    ids_ack_i = 1'b0;
    ireqready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    exs_pc_wr_i  = 1'b1;
    exs_pc_din_i = 32'h200;
    ids_ack_i    = 1'b1;
    @(negedge clk_i);
    n_total++;
    if (irspvalid_i !== 1'b1 || ids_dav_o !== 1'b1)
      $display("FAIL coll_setup: rsp=%b dav=%b want 1/1", irspvalid_i, ids_dav_o);
    else n_pass++;
    @(posedge clk_i); #1 exs_pc_wr_i = 1'b0;
    @(negedge clk_i);
    n_total++;
    if (ids_dav_o !== 1'b0) $display("FAIL coll_flush: dav=%b want 0", ids_dav_o); else n_pass++;
    repeat (10) @(negedge clk_i);
    drain("coll");
    n_total++;
    if (got.size() == 0 || got[0].pc !== 32'h200 || got[0].sofid !== RV_SOFID_JUMP)
      $display("FAIL coll_first: entries=%0d pc0=%h want 200 JUMP", got.size(),
               (got.size() > 0) ? got[0].pc : 32'hx);
    else n_pass++;
    n_total++;
    if (got.size() + 4 != req_log.size())
      $display("FAIL coll_count: entries=%0d reqs=%0d want reqs-4", got.size(), req_log.size());
    else n_pass++;
`ifdef MERLIN_PFU_PERF_EN
    n_total++;
    if (perf_drop_o !== 32'd2) $display("FAIL coll_perf_drop: got %0d want 2", perf_drop_o); else n_pass++;
`endif
  endtask

  task automatic test_error;
    int bad;
    apply_reset();
    lat = 1;
    err_at = 1;
    ids_ack_i = 1'b1;
    ireqready_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1 ireqready_i = 1'b0;
    drain("err");
    n_total++;
    if (got.size() != 8) $display("FAIL err_entries: got %0d want 8", got.size()); else n_pass++;
    bad = 0;
    foreach (got[i]) if (got[i].ferr !== ((i == 1) ? 1'b1 : 1'b0)) bad++;
    n_total++;
    if (bad != 0) $display("FAIL err_ferr: %0d wrong ferr flags want 0", bad); else n_pass++;
    n_total++;
    if (got.size() < 3 || got[2].pc !== 32'h8)
      $display("FAIL err_continue: entries=%0d pc2=%h want 8", got.size(),
               (got.size() > 2) ? got[2].pc : 32'hx);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_outstanding();
    test_credit();
    test_vector();
    test_vector_collision();
    test_error();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
